// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: IF/ID payload, fetch FSM states,
// instruction ROM size and the bubble encoding.
package cpu_pkg;

  localparam int unsigned INSTRUCT_MEM_SIZE = 1024;
  localparam logic [31:0] NOP_INSTR         = 32'hD503201F;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
  } if_id_t;

  function automatic if_id_t make_bubble(input logic [31:0] nop);
    if_id_t b;
    b.valid = 1'b0;
    b.pc    = 64'd0;
    b.instr = nop;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A bubble beats a load, and a load beats hold;
// reset leaves a bubble in place.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP = cpu_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t entry_q;

  always_ff @(posedge clk) begin
    if (reset || bubble_i) begin
      entry_q <= make_bubble(NOP);
    end else if (load_i) begin
      entry_q <= d_i;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the ROM address, fills IF/ID, keeps a branch
// redirect pending across stalls and halts for good on a misaligned or out-of-range PC.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned MEM_SIZE  = cpu_pkg::INSTRUCT_MEM_SIZE,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic        if_id_valid,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        fault
);

  localparam logic [63:0] MEM_LIMIT = 64'(MEM_SIZE);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic         pend_q, pend_d;
  logic [63:0]  pend_tgt_q, pend_tgt_d;

  logic   pc_bad;
  logic   ifid_load;
  logic   ifid_bubble;
  if_id_t ifid_d;
  if_id_t ifid_q;

  // Wrap-around past 2^64 lands on a misaligned or huge value, so this catches it too.
  assign pc_bad    = (pc_q[1:0] != 2'b00) || ((pc_q + 64'd3) >= MEM_LIMIT);
  assign imem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (pc_bad) state_d = FAULT;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  always_comb begin
    fault       = (state_q == FAULT);
    ifid_bubble = (state_q == FAULT) || pc_bad || flush;
    ifid_load   = !stall;
  end

  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (state_q == RUN && !pc_bad) begin
      if (stall) begin
        // Remember the newest taken branch until the stall lifts.
        if (br_taken) begin
          pend_d     = 1'b1;
          pend_tgt_d = br_target;
        end
      end else if (br_taken || pend_q) begin
        pc_d   = br_taken ? br_target : pend_tgt_q;
        pend_d = 1'b0;
      end else begin
        pc_d = pc_q + 64'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= 64'd0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  always_comb begin
    ifid_d.valid = 1'b1;
    ifid_d.pc    = pc_q;
    ifid_d.instr = imem_instr;
  end

  if_id_reg #(
    .NOP(NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .bubble_i(ifid_bubble),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign if_id_valid = ifid_q.valid;
  assign if_id_pc    = ifid_q.pc;
  assign if_id_instr = ifid_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random
// stall/flush/branch/reset traffic checked every cycle against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'hD503201F;
  localparam int          MEMB = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] br_target = 64'd0;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rom [MEMB/4];

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr < 64'(MEMB)) imem_instr = rom[imem_addr[9:2]];
    else                       imem_instr = 32'hDEAD_BEEF;
  end

  fetch_stage #(
    .RESET_PC (64'd0),
    .MEM_SIZE (MEMB),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .stall      (stall),
    .flush      (flush),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .if_id_valid(if_id_valid),
    .if_id_pc   (if_id_pc),
    .if_id_instr(if_id_instr),
    .fault      (fault)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the fetch pipeline described as plain variables.
  logic [63:0] m_pc;
  logic        m_pend;
  logic [63:0] m_tgt;
  logic        m_fault;
  logic        m_valid;
  logic [63:0] m_ifpc;
  logic [31:0] m_ifinstr;
  bit          m_live = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 64'd0; m_pend = 0; m_tgt = 64'd0; m_fault = 0;
      m_valid = 0; m_ifpc = 64'd0; m_ifinstr = NOP;
      m_live = 1;
    end else if (m_live) begin
      if (m_fault) begin
        m_valid = 0; m_ifpc = 64'd0; m_ifinstr = NOP;
      end else if (m_pc % 4 != 0 || m_pc > 64'(MEMB - 4)) begin
        m_fault = 1;
        m_valid = 0; m_ifpc = 64'd0; m_ifinstr = NOP;
      end else begin
        if (flush) begin
          m_valid = 0; m_ifpc = 64'd0; m_ifinstr = NOP;
        end else if (!stall) begin
          m_valid = 1; m_ifpc = m_pc; m_ifinstr = rom[m_pc / 4];
        end
        if (stall) begin
          if (br_taken) begin m_pend = 1; m_tgt = br_target; end
        end else if (br_taken) begin
          m_pc = br_target; m_pend = 0;
        end else if (m_pend) begin
          m_pc = m_tgt; m_pend = 0;
        end else begin
          m_pc = m_pc + 64'd4;
        end
      end
    end
    #1;
    if (m_live) begin
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_valid", 64'(if_id_valid), 64'(m_valid));
      chk("m_if_pc", if_id_pc, m_ifpc);
      chk("m_if_instr", 64'(if_id_instr), 64'(m_ifinstr));
      chk("m_fault", 64'(fault), 64'(m_fault));
      n_cmp++;
      if ($isunknown(if_id_instr)) begin
        n_err++;
        $display("FAIL m_instr_known: got %h expected no X", if_id_instr);
      end
    end
  end

  task automatic cyc(input logic s, input logic f, input logic b, input logic [63:0] t);
    @(negedge clk);
    reset = 0; stall = s; flush = f; br_taken = b; br_target = t;
    @(posedge clk);
    #2;
    $display("cyc stall=%0d flush=%0d br=%0d tgt=%0d -> addr=%0d v=%0d ifpc=%0d instr=%h fault=%0d",
             s, f, b, t, imem_addr, if_id_valid, if_id_pc, if_id_instr, fault);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; stall = 0; flush = 0; br_taken = 0; br_target = 64'd0;
    @(posedge clk);
    #2;
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < MEMB/4; i++) rom[i] = $urandom;

    // 1: reset and sequential fetch
    do_reset();
    chk("t1_rst_addr", imem_addr, 64'd0);
    chk("t1_rst_valid", 64'(if_id_valid), 64'd0);
    chk("t1_rst_instr", 64'(if_id_instr), 64'(NOP));
    chk("t1_rst_fault", 64'(fault), 64'd0);
    cyc(0, 0, 0, 64'd0);
    chk("t1_addr1", imem_addr, 64'd4);
    chk("t1_valid1", 64'(if_id_valid), 64'd1);
    chk("t1_ifpc1", if_id_pc, 64'd0);
    chk("t1_instr1", 64'(if_id_instr), 64'(rom[0]));
    cyc(0, 0, 0, 64'd0);
    chk("t1_addr2", imem_addr, 64'd8);
    chk("t1_ifpc2", if_id_pc, 64'd4);
    cyc(0, 0, 0, 64'd0);
    chk("t1_addr3", imem_addr, 64'd12);
    chk("t1_ifpc3", if_id_pc, 64'd8);
    chk("t1_instr3", 64'(if_id_instr), 64'(rom[2]));

    // 2: taken branch with delay slot
    do_reset(); free(2);
    cyc(0, 0, 1, 64'd64);
    chk("t2_slot_pc", if_id_pc, 64'd8);
    chk("t2_slot_valid", 64'(if_id_valid), 64'd1);
    chk("t2_addr_tgt", imem_addr, 64'd64);
    cyc(0, 0, 0, 64'd0);
    chk("t2_ifpc_tgt", if_id_pc, 64'd64);
    chk("t2_addr_next", imem_addr, 64'd68);

    // 3: branch held pending across a two-cycle stall
    do_reset(); free(4);
    cyc(1, 0, 1, 64'd40);
    chk("t3_hold1", imem_addr, 64'd16);
    cyc(1, 0, 1, 64'd40);
    chk("t3_hold2", imem_addr, 64'd16);
    chk("t3_ifpc_hold", if_id_pc, 64'd12);
    cyc(0, 0, 0, 64'd0);
    chk("t3_jump", imem_addr, 64'd40);
    chk("t3_slot_pc", if_id_pc, 64'd16);

    // 4: flush without stall
    do_reset(); free(5);
    cyc(0, 1, 0, 64'd0);
    chk("t4_valid", 64'(if_id_valid), 64'd0);
    chk("t4_instr", 64'(if_id_instr), 64'(NOP));
    chk("t4_ifpc", if_id_pc, 64'd0);
    chk("t4_addr", imem_addr, 64'd24);

    // 5: misaligned target faults one edge later
    do_reset();
    cyc(0, 0, 1, 64'd1022);
    chk("t5_addr", imem_addr, 64'd1022);
    chk("t5_nofault", 64'(fault), 64'd0);
    cyc(0, 0, 0, 64'd0);
    chk("t5_fault", 64'(fault), 64'd1);
    chk("t5_valid", 64'(if_id_valid), 64'd0);
    chk("t5_frozen1", imem_addr, 64'd1022);
    cyc(0, 0, 1, 64'd8);
    chk("t5_frozen2", imem_addr, 64'd1022);
    chk("t5_sticky", 64'(fault), 64'd1);
    do_reset();
    chk("t5_clr_fault", 64'(fault), 64'd0);
    chk("t5_clr_addr", imem_addr, 64'd0);

    // 6: last word fetched, then end of ROM faults
    do_reset();
    cyc(0, 0, 1, 64'd1016);
    cyc(0, 0, 0, 64'd0);
    chk("t6_addr1020", imem_addr, 64'd1020);
    cyc(0, 0, 0, 64'd0);
    chk("t6_ifpc1020", if_id_pc, 64'd1020);
    chk("t6_instr1020", 64'(if_id_instr), 64'(rom[255]));
    chk("t6_addr1024", imem_addr, 64'd1024);
    chk("t6_nofault", 64'(fault), 64'd0);
    cyc(0, 0, 0, 64'd0);
    chk("t6_fault", 64'(fault), 64'd1);
    chk("t6_instr_nop", 64'(if_id_instr), 64'(NOP));

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        s, f, b;
      logic [63:0] t;
      if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        s = ($urandom_range(0, 3) == 0);
        f = ($urandom_range(0, 6) == 0);
        b = ($urandom_range(0, 6) == 0);
        if ($urandom_range(0, 15) == 0) t = 64'($urandom_range(0, 1100));
        else                            t = 64'($urandom_range(0, 255)) * 64'd4;
        cyc(s, f, b, t);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
